// File: rtl/id_issue_stage.sv
// Decode/issue stage for the 16-bit ALU pipeline: decodes one fetch word per cycle, reads operands,
// registers the issue bundle for EX and stalls RAW/WAW hazards with a per-register busy scoreboard.
module id_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_valid_i,
  input  logic [15:0]       if_instr_i,
  output logic              id_ready_o,
  output logic [RA_W-1:0]   rf_raddr1_o,
  output logic [RA_W-1:0]   rf_raddr2_o,
  input  logic [DATA_W-1:0] rf_rdata1_i,
  input  logic [DATA_W-1:0] rf_rdata2_i,
  input  logic              ex_ready_i,
  output logic              id_valid_o,
  output logic [4:0]        aluOp_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [7:0]        imm_o,
  output logic              wreg_o,
  output logic [RA_W-1:0]   waddr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              branch_o,
  output logic              illegal_o,
  input  logic              wb_we_i,
  input  logic [RA_W-1:0]   wb_addr_i,
  input  logic              flush_i
);

  localparam logic [4:0] OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4,  OP_MOD  = 5'd5,  OP_AND  = 5'd6,  OP_OR   = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8,  OP_INC  = 5'd9,  OP_DEC  = 5'd10, OP_NOT  = 5'd11;
  localparam logic [4:0] OP_SLL  = 5'd12, OP_SAL  = 5'd13, OP_SLR  = 5'd14, OP_SAR  = 5'd15;
  localparam logic [4:0] OP_MOV  = 5'd16, OP_LOD  = 5'd17, OP_LODI = 5'd18, OP_MOVI = 5'd19;
  localparam logic [4:0] OP_STO  = 5'd20, OP_STOI = 5'd21, OP_JEQ  = 5'd22, OP_JNE  = 5'd23;
  localparam logic [4:0] OP_JG   = 5'd24, OP_JGU  = 5'd25, OP_JL   = 5'd26, OP_JLU  = 5'd27;
  localparam logic [4:0] OP_JMP  = 5'd28, OP_JMPI = 5'd29;

  logic [4:0]      opcode;
  logic [RA_W-1:0] ra, rb;
  logic            rd_a, rd_b, wr, m_rd, m_wr, br, legal;
  logic [NREG-1:0] busy, busy_nxt;
  logic            hazard, adv, accept;

  assign opcode      = if_instr_i[15:11];
  assign ra          = if_instr_i[10:8];
  assign rb          = if_instr_i[7:5];
  assign rf_raddr1_o = ra;
  assign rf_raddr2_o = rb;

  always_comb begin
    rd_a  = 1'b0;
    rd_b  = 1'b0;
    wr    = 1'b0;
    m_rd  = 1'b0;
    m_wr  = 1'b0;
    br    = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR: begin
        rd_a = 1'b1; rd_b = 1'b1; wr = 1'b1;
      end
      OP_INC, OP_DEC, OP_NOT, OP_SLL, OP_SAL, OP_SLR, OP_SAR: begin
        rd_a = 1'b1; wr = 1'b1;
      end
      OP_MOV:           begin rd_b = 1'b1; wr = 1'b1; end
      OP_LOD, OP_LODI:  begin rd_b = 1'b1; wr = 1'b1; m_rd = 1'b1; end
      OP_MOVI:          wr = 1'b1;
      OP_STO, OP_STOI:  begin rd_a = 1'b1; rd_b = 1'b1; m_wr = 1'b1; end
      OP_JEQ, OP_JNE, OP_JG, OP_JGU, OP_JL, OP_JLU: begin
        rd_a = 1'b1; rd_b = 1'b1; br = 1'b1;
      end
      OP_JMP:           begin rd_a = 1'b1; br = 1'b1; end
      OP_JMPI:          br = 1'b1;
      OP_NOP:           ;
      default:          legal = 1'b0;
    endcase
  end

  // Hazard looks only at the registered busy bits, so a write-back in the
  // same cycle releases the stall one cycle later.
  assign hazard     = (rd_a & busy[ra]) | (rd_b & busy[rb]) | (wr & busy[ra]);
  assign adv        = !id_valid_o | ex_ready_i;
  assign id_ready_o = adv & !hazard & !flush_i;
  assign accept     = if_valid_i & id_ready_o;

  // Clears first, set last: a new writer of a register wins over its retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wb_we_i)
      busy_nxt[wb_addr_i] = 1'b0;
    if (flush_i && id_valid_o && wreg_o)
      busy_nxt[waddr_o] = 1'b0;
    if (accept && wr)
      busy_nxt[ra] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_valid_o <= 1'b0;
      aluOp_o    <= OP_NOP;
      data1_o    <= '0;
      data2_o    <= '0;
      imm_o      <= '0;
      wreg_o     <= 1'b0;
      waddr_o    <= '0;
      mem_rd_o   <= 1'b0;
      mem_wr_o   <= 1'b0;
      branch_o   <= 1'b0;
    end else if (flush_i || adv) begin
      id_valid_o <= accept;
      aluOp_o    <= (accept && legal) ? opcode : OP_NOP;
      data1_o    <= accept ? rf_rdata1_i : '0;
      data2_o    <= accept ? rf_rdata2_i : '0;
      imm_o      <= accept ? if_instr_i[7:0] : '0;
      wreg_o     <= accept & wr;
      waddr_o    <= accept ? ra : '0;
      mem_rd_o   <= accept & m_rd;
      mem_wr_o   <= accept & m_wr;
      branch_o   <= accept & br;
    end
  end

  // Kept outside the hold path so an undefined opcode reports exactly once even under backpressure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      illegal_o <= 1'b0;
    else
      illegal_o <= accept & !legal;
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: hand-computed vectors for issue, hazards, backpressure,
// flush, illegal opcodes, set/clear races and asynchronous reset.
module tb_id_issue_stage;

  localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  SUB = 5'd2,  INC = 5'd9,  LOD = 5'd17;
  localparam logic [4:0] MOVI = 5'd19, STO = 5'd20, JEQ = 5'd22, JMP = 5'd28, BAD = 5'd30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic        id_ready;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        ex_ready = 1'b1;
  logic        id_valid;
  logic [4:0]  alu_op;
  logic [15:0] data1, data2;
  logic [7:0]  imm;
  logic        wreg;
  logic [2:0]  waddr;
  logic        mem_rd, mem_wr, branch, illegal;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic        flush = 1'b0;

  logic [15:0] regs [8];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [6:0]  exp_q [$];

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  id_issue_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .if_valid_i(if_valid), .if_instr_i(if_instr),
    .id_ready_o(id_ready), .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
    .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2), .ex_ready_i(ex_ready),
    .id_valid_o(id_valid), .aluOp_o(alu_op), .data1_o(data1), .data2_o(data2),
    .imm_o(imm), .wreg_o(wreg), .waddr_o(waddr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .branch_o(branch), .illegal_o(illegal), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
    .flush_i(flush)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] a, input logic [7:0] low);
    return {op, a, low};
  endfunction

  function automatic logic [7:0] rr(input logic [2:0] b);
    return {b, 5'b0};
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr);
    if_valid = v;
    if_instr = instr;
  endtask

  task automatic wb_clear(input logic [2:0] a);
    wb_we = 1'b1;
    wb_addr = a;
    tick();
    wb_we = 1'b0;
  endtask

  logic [4:0]  tp_op  [3];
  logic [7:0]  tp_low [3];
  logic [6:0]  tp_exp [3];

  initial begin
    regs[0] = 16'h0011; regs[1] = 16'd5;    regs[2] = 16'd7;    regs[3] = 16'h0033;
    regs[4] = 16'h0044; regs[5] = 16'h0055; regs[6] = 16'h0066; regs[7] = 16'h0077;

    #2;
    check_eq("rst_valid", id_valid, 0);
    check_eq("rst_aluop", alu_op, NOP);
    check_eq("rst_wreg", wreg, 0);
    check_eq("rst_data1", data1, 0);
    check_eq("rst_illegal", illegal, 0);
    tick();
    rst_n = 1'b1;

    // ADD R1,R2
    drive(1, mk(ADD, 3'd1, rr(3'd2)));
    settle();
    check_eq("add_ready", id_ready, 1);
    check_eq("add_raddr1", rf_raddr1, 1);
    check_eq("add_raddr2", rf_raddr2, 2);
    tick();
    drive(0, '0);
    check_eq("add_valid", id_valid, 1);
    check_eq("add_aluop", alu_op, ADD);
    check_eq("add_data1", data1, 5);
    check_eq("add_data2", data2, 7);
    check_eq("add_waddr", waddr, 1);
    check_eq("add_wreg", wreg, 1);
    wb_clear(3'd1);
    check_eq("bubble_valid", id_valid, 0);

    // LOD R3,R4 then dependent ADD R3,R1
    drive(1, mk(LOD, 3'd3, rr(3'd4)));
    tick();
    check_eq("lod_memrd", mem_rd, 1);
    check_eq("lod_data2", data2, 16'h0044);
    drive(1, mk(ADD, 3'd3, rr(3'd1)));
    settle();
    check_eq("raw_stall0", id_ready, 0);
    tick();
    check_eq("raw_bubble", id_valid, 0);
    check_eq("raw_stall1", id_ready, 0);
    wb_we = 1'b1;
    wb_addr = 3'd3;
    settle();
    check_eq("raw_samecyc_wb", id_ready, 0);
    tick();
    wb_we = 1'b0;
    check_eq("raw_after_wb_valid", id_valid, 0);
    check_eq("raw_after_wb_ready", id_ready, 1);
    tick();
    drive(0, '0);
    check_eq("raw_issue_valid", id_valid, 1);
    check_eq("raw_issue_aluop", alu_op, ADD);
    check_eq("raw_issue_waddr", waddr, 3);
    wb_clear(3'd3);

    // MOVI R2,0x80 held under EX backpressure
    drive(1, mk(MOVI, 3'd2, 8'h80));
    tick();
    ex_ready = 1'b0;
    drive(1, mk(NOP, 3'd0, 8'h00));
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("hold_ready", id_ready, 0);
      check_eq("hold_valid", id_valid, 1);
      check_eq("hold_aluop", alu_op, MOVI);
      check_eq("hold_imm", imm, 8'h80);
      check_eq("hold_waddr", waddr, 2);
      check_eq("hold_wreg", wreg, 1);
      tick();
    end
    ex_ready = 1'b1;
    settle();
    check_eq("hold_release_ready", id_ready, 1);
    tick();
    drive(0, '0);
    check_eq("hold_next_aluop", alu_op, NOP);
    check_eq("hold_next_valid", id_valid, 1);
    wb_clear(3'd2);

    // INC R5, flush while in the output register, refetch
    drive(1, mk(INC, 3'd5, 8'h00));
    tick();
    check_eq("inc_valid", id_valid, 1);
    flush = 1'b1;
    settle();
    check_eq("flush_ready", id_ready, 0);
    tick();
    flush = 1'b0;
    check_eq("flush_valid", id_valid, 0);
    check_eq("flush_aluop", alu_op, NOP);
    check_eq("flush_wreg", wreg, 0);
    settle();
    check_eq("refetch_ready", id_ready, 1);
    tick();
    drive(0, '0);
    check_eq("refetch_valid", id_valid, 1);
    check_eq("refetch_aluop", alu_op, INC);
    check_eq("refetch_data1", data1, 16'h0055);
    wb_clear(3'd5);

    // Undefined opcode
    drive(1, mk(BAD, 3'd4, 8'h00));
    tick();
    drive(0, '0);
    check_eq("ill_pulse", illegal, 1);
    check_eq("ill_aluop", alu_op, NOP);
    check_eq("ill_wreg", wreg, 0);
    check_eq("ill_valid", id_valid, 1);
    tick();
    check_eq("ill_pulse_end", illegal, 0);

    // SUB R6,R0 with same-cycle write-back to R6: busy must remain set
    drive(1, mk(SUB, 3'd6, rr(3'd0)));
    wb_we = 1'b1;
    wb_addr = 3'd6;
    tick();
    wb_we = 1'b0;
    drive(1, mk(MOVI, 3'd6, 8'h01));
    settle();
    check_eq("set_wins_ready", id_ready, 0);
    tick();
    drive(0, '0);
    wb_clear(3'd6);
    drive(1, mk(MOVI, 3'd6, 8'h01));
    settle();
    check_eq("r6_free_ready", id_ready, 1);
    drive(0, '0);
    wb_clear(3'd6);

    // back-to-back independent issue through the expected queue
    tp_op[0] = STO; tp_low[0] = rr(3'd2); tp_exp[0] = {1'b1, 1'b0, STO};
    tp_op[1] = JEQ; tp_low[1] = rr(3'd2); tp_exp[1] = {1'b0, 1'b1, JEQ};
    tp_op[2] = JMP; tp_low[2] = 8'h00;    tp_exp[2] = {1'b0, 1'b1, JMP};
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(tp_op[i], 3'd1, tp_low[i]));
      exp_q.push_back(tp_exp[i]);
      tick();
      check_eq("tp_valid", id_valid, 1);
      check_eq("tp_bundle", {mem_wr, branch, alu_op}, exp_q.pop_front());
    end
    drive(0, '0);
    tick();

    // async reset in the middle of a stall
    drive(1, mk(MOVI, 3'd7, 8'h05));
    tick();
    ex_ready = 1'b0;
    settle();
    check_eq("pre_rst_ready", id_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", id_valid, 0);
    check_eq("arst_wreg", wreg, 0);
    check_eq("arst_imm", imm, 0);
    #1 rst_n = 1'b1;
    #1;
    check_eq("arst_sb_clear", id_ready, 1);
    tick();
    drive(0, '0);
    ex_ready = 1'b1;
    check_eq("arst_reissue", id_valid, 1);
    check_eq("arst_reissue_imm", imm, 8'h05);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
